// File: rtl/secuenciador_ctrl.sv
// Beam configuration playback sequencer: host loads a word table byte-wise,
// then seq_en replays it as a single pass, in a loop or step by step.
module secuenciador_ctrl #(
    parameter int DEPTH       = 16,
    parameter int STEP_CYCLES = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        seq_en,
    input  logic [1:0]  mode,
    input  logic [7:0]  dato,
    input  logic        wr,
    input  logic        Stb,
    output logic [15:0] theBeanConfig
);

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(2 * DEPTH + 1);
    localparam int CW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        STEP
    } state_t;

    logic [15:0]   mem [DEPTH];

    state_t        state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [15:0]   out_q, out_d;
    logic [LW-1:0] len_q, len_d;
    logic [PW-1:0] ptr_q, ptr_d;
    logic [1:0]    mode_l_q, mode_l_d;
    logic          seq_en_q, seq_en_d;
    logic          wr_q, wr_d;

    logic          start_ev;
    logic          we;
    logic [IW-1:0] wsel;
    logic [IW-1:0] idx_inc;
    logic          idx_last;

    assign theBeanConfig = out_q;
    assign seq_en_d      = seq_en;
    assign wr_d          = wr;
    assign start_ev      = seq_en & ~seq_en_q;
    assign wsel          = IW'(ptr_q >> 1);
    assign idx_inc       = idx_q + 1'b1;
    assign idx_last      = (LW'(idx_q) == len_q - LW'(1));

    // Byte pointer and table length; LEN is captured while ptr_q still holds the session count
    always_comb begin
        ptr_d = ptr_q;
        we    = 1'b0;
        if (!wr) begin
            ptr_d = '0;
        end else if (Stb && (ptr_q < PW'(2 * DEPTH))) begin
            we    = 1'b1;
            ptr_d = ptr_q + 1'b1;
        end
        len_d = (wr_q && !wr) ? LW'(ptr_q >> 1) : len_q;
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        out_d    = out_q;
        mode_l_d = mode_l_q;
        if (wr) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else if (mode == 2'b00) begin
            state_d = IDLE;
            cnt_d   = '0;
            out_d   = '0;
        end else begin
            case (state_q)
                IDLE, RUN: begin
                    if (start_ev) begin
                        if (len_d != '0) begin
                            mode_l_d = mode;
                            idx_d    = '0;
                            cnt_d    = '0;
                            out_d    = mem[0];
                            state_d  = (mode == 2'b11) ? STEP : RUN;
                        end
                    end else if (state_q == RUN) begin
                        if (cnt_q == CW'(STEP_CYCLES - 1)) begin
                            cnt_d = '0;
                            if (idx_last) begin
                                if (mode_l_q == 2'b10) begin
                                    idx_d = '0;
                                    out_d = mem[0];
                                end else begin
                                    state_d = IDLE;
                                end
                            end else begin
                                idx_d = idx_inc;
                                out_d = mem[idx_inc];
                            end
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                STEP: begin
                    if (mode != 2'b11) begin
                        state_d = IDLE;
                    end else if (start_ev) begin
                        idx_d = idx_last ? '0 : idx_inc;
                        out_d = idx_last ? mem[0] : mem[idx_inc];
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (we) begin
            if (ptr_q[0]) begin
                mem[wsel][7:0] <= dato;
            end else begin
                mem[wsel][15:8] <= dato;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            cnt_q    <= '0;
            out_q    <= '0;
            len_q    <= '0;
            ptr_q    <= '0;
            mode_l_q <= '0;
            seq_en_q <= 1'b0;
            wr_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            out_q    <= out_d;
            len_q    <= len_d;
            ptr_q    <= ptr_d;
            mode_l_q <= mode_l_d;
            seq_en_q <= seq_en_d;
            wr_q     <= wr_d;
        end
    end

endmodule

// File: tb/tb_secuenciador_ctrl.sv
// Directed bench for secuenciador_ctrl: per-cycle vector table plus hand-written
// sequences for table overflow and reset during playback.
module tb_secuenciador_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        seq_en;
    logic [1:0]  mode;
    logic [7:0]  dato;
    logic        wr;
    logic        Stb;
    logic [15:0] theBeanConfig;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic        rst;
        logic        se;
        logic [1:0]  mode;
        logic        wr;
        logic        stb;
        logic [7:0]  dato;
        int          n;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs[$];

    secuenciador_ctrl #(.DEPTH(16), .STEP_CYCLES(8)) dut (
        .clk           (clk),
        .rst           (rst),
        .seq_en        (seq_en),
        .mode          (mode),
        .dato          (dato),
        .wr            (wr),
        .Stb           (Stb),
        .theBeanConfig (theBeanConfig)
    );

    always #5 clk = ~clk;

    task automatic add(input logic r, input logic se, input logic [1:0] m,
                       input logic w, input logic s, input logic [7:0] d,
                       input int n, input logic [15:0] e);
        vec_t v;
        v.rst = r; v.se = se; v.mode = m; v.wr = w; v.stb = s;
        v.dato = d; v.n = n; v.exp = e;
        vecs.push_back(v);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [15:0] exp);
        n_chk++;
        if (theBeanConfig !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, theBeanConfig, exp);
        end
    endtask

    initial begin
        rst = 1'b1; seq_en = 1'b0; mode = 2'b00; dato = 8'h00; wr = 1'b0; Stb = 1'b0;
        tick;
        chk("reset", 16'h0000);
        rst = 1'b0;

        // No data loaded: pulses and stray strobes must leave the output at zero
        mode = 2'b01;
        for (int c = 0; c < 330; c++) begin
            seq_en = ((c % 103) == 5);
            dato   = 8'(c);
            Stb    = c[0];
            tick;
            chk("nodata", 16'h0000);
        end
        seq_en = 1'b0; Stb = 1'b0;

        // load 12 34 56 78 9A -> LEN=2, single pass
        add(0,0,2'd1,1,0,8'h00,1,16'h0000);
        add(0,0,2'd1,1,1,8'h12,1,16'h0000);
        add(0,0,2'd1,1,1,8'h34,1,16'h0000);
        add(0,0,2'd1,1,1,8'h56,1,16'h0000);
        add(0,0,2'd1,1,1,8'h78,1,16'h0000);
        add(0,0,2'd1,1,1,8'h9A,1,16'h0000);
        add(0,0,2'd1,0,0,8'h00,1,16'h0000);
        add(0,1,2'd1,0,0,8'h00,1,16'h1234);
        add(0,0,2'd1,0,0,8'h00,7,16'h1234);
        add(0,0,2'd1,0,0,8'h00,8,16'h5678);
        add(0,0,2'd1,0,0,8'h00,6,16'h5678);
        // loop, then stop
        add(0,1,2'd2,0,0,8'h00,1,16'h1234);
        add(0,0,2'd2,0,0,8'h00,7,16'h1234);
        add(0,0,2'd2,0,0,8'h00,8,16'h5678);
        add(0,0,2'd2,0,0,8'h00,8,16'h1234);
        add(0,0,2'd2,0,0,8'h00,3,16'h5678);
        add(0,0,2'd0,0,0,8'h00,1,16'h0000);
        add(0,0,2'd0,0,0,8'h00,2,16'h0000);
        // stop together with a start event during RUN
        add(0,1,2'd2,0,0,8'h00,1,16'h1234);
        add(0,0,2'd2,0,0,8'h00,3,16'h1234);
        add(0,1,2'd0,0,0,8'h00,1,16'h0000);
        add(0,0,2'd0,0,0,8'h00,2,16'h0000);
        // manual step over 1111 2222 3333
        add(0,0,2'd3,1,0,8'h00,1,16'h0000);
        add(0,0,2'd3,1,1,8'h11,1,16'h0000);
        add(0,0,2'd3,1,1,8'h11,1,16'h0000);
        add(0,0,2'd3,1,1,8'h22,1,16'h0000);
        add(0,0,2'd3,1,1,8'h22,1,16'h0000);
        add(0,0,2'd3,1,1,8'h33,1,16'h0000);
        add(0,0,2'd3,1,1,8'h33,1,16'h0000);
        add(0,0,2'd3,0,0,8'h00,1,16'h0000);
        add(0,1,2'd3,0,0,8'h00,1,16'h1111);
        add(0,0,2'd3,0,0,8'h00,2,16'h1111);
        add(0,1,2'd3,0,0,8'h00,1,16'h2222);
        add(0,0,2'd3,0,0,8'h00,2,16'h2222);
        add(0,1,2'd3,0,0,8'h00,1,16'h3333);
        add(0,0,2'd3,0,0,8'h00,2,16'h3333);
        add(0,1,2'd3,0,0,8'h00,1,16'h1111);
        add(0,1,2'd3,0,0,8'h00,4,16'h1111);
        add(0,0,2'd1,0,0,8'h00,2,16'h1111);
        // retrigger mid-RUN
        add(0,1,2'd1,0,0,8'h00,1,16'h1111);
        add(0,0,2'd1,0,0,8'h00,7,16'h1111);
        add(0,0,2'd1,0,0,8'h00,3,16'h2222);
        add(0,1,2'd1,0,0,8'h00,1,16'h1111);
        add(0,0,2'd1,0,0,8'h00,7,16'h1111);
        add(0,0,2'd1,0,0,8'h00,1,16'h2222);
        // write abort during RUN, pulse with wr=1 dropped
        add(0,0,2'd1,1,0,8'h00,10,16'h2222);
        add(0,1,2'd1,1,0,8'h00,1,16'h2222);
        add(0,0,2'd1,1,0,8'h00,1,16'h2222);
        // zero-byte session: start at the wr falling edge sees LEN=0
        add(0,1,2'd1,0,0,8'h00,1,16'h2222);
        add(0,0,2'd1,0,0,8'h00,3,16'h2222);
        add(0,1,2'd1,0,0,8'h00,1,16'h2222);
        add(0,0,2'd1,0,0,8'h00,1,16'h2222);
        // start at the wr falling edge sees the freshly loaded LEN=2
        add(0,0,2'd2,1,0,8'h00,1,16'h2222);
        add(0,0,2'd2,1,1,8'hAB,1,16'h2222);
        add(0,0,2'd2,1,1,8'hCD,1,16'h2222);
        add(0,0,2'd2,1,1,8'hEF,1,16'h2222);
        add(0,0,2'd2,1,1,8'h01,1,16'h2222);
        add(0,1,2'd2,0,0,8'h00,1,16'hABCD);
        add(0,0,2'd2,0,0,8'h00,7,16'hABCD);
        add(0,0,2'd2,0,0,8'h00,8,16'hEF01);
        add(0,0,2'd2,0,0,8'h00,2,16'hABCD);
        add(0,0,2'd0,0,0,8'h00,1,16'h0000);

        for (int i = 0; i < vecs.size(); i++) begin
            rst = vecs[i].rst; seq_en = vecs[i].se; mode = vecs[i].mode;
            wr = vecs[i].wr; Stb = vecs[i].stb; dato = vecs[i].dato;
            for (int k = 0; k < vecs[i].n; k++) begin
                tick;
                chk($sformatf("vec%0d", i), vecs[i].exp);
            end
        end
        seq_en = 1'b0; wr = 1'b0; Stb = 1'b0;

        // Overflow: 2*DEPTH+4 bytes, byte i = i; LEN must be 16, mem[0] untouched by extras
        mode = 2'b01; wr = 1'b1;
        for (int i = 0; i < 36; i++) begin
            Stb  = 1'b1;
            dato = 8'(i);
            tick;
            chk("ovf_load", 16'h0000);
        end
        Stb = 1'b0; wr = 1'b0;
        tick;
        chk("ovf_len", 16'h0000);
        seq_en = 1'b1;
        tick;
        chk("ovf_first", 16'h0001);
        seq_en = 1'b0;
        for (int c = 1; c < 141; c++) begin
            int k;
            logic [15:0] e;
            k = c / 8;
            if (k > 15) k = 15;
            e = {8'(2 * k), 8'(2 * k + 1)};
            tick;
            chk("ovf_pass", e);
        end

        // Reset during loop playback aborts and clears LEN
        mode = 2'b10; seq_en = 1'b1;
        tick;
        chk("rst_start", 16'h0001);
        seq_en = 1'b0;
        repeat (3) tick;
        rst = 1'b1;
        tick;
        chk("rst_mid", 16'h0000);
        rst = 1'b0; mode = 2'b01; seq_en = 1'b1;
        tick;
        chk("rst_len0", 16'h0000);
        seq_en = 1'b0;
        tick;
        chk("rst_hold", 16'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/secuenciador_ctrl.md
# secuenciador_ctrl

Playback sequencer that drives the 16-bit beam configuration word (`theBeanConfig`) from a small on-chip table of configuration words. A host loads the table byte-wise over the `dato`/`wr`/`Stb` write port. A `seq_en` pulse then replays the table in single-pass, looping or manual-step mode. The block sits between the host byte interface and the beam-configuration consumers.

## Interface
- `DEPTH`, 16: table entries (16-bit words); index width is clog2(DEPTH).
- `STEP_CYCLES`, 8: dwell in clock cycles per entry during automatic playback (≥1).
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  reset; synchronous and active-high.
- `seq_en`  in  1  start/advance request; rising edge is the event.
- `mode`  in  2  00 stop, 01 single pass, 10 loop, 11 manual step.
- `dato`  in  8  write data byte.
- `wr`  in  1  write-session enable; high = table loading.
- `Stb`  in  1  byte strobe; one byte written per clock with `wr`=1 and `Stb`=1.
- `theBeanConfig`  out  16  registered configuration word.

## Operation
- **Edge detect.** `seq_en` is registered each cycle. A start event is `seq_en`=1 while the previous sample was 0. A level held high gives one event.
- **Loading.**
  - While `wr`=0, the byte pointer is 0.
  - With `wr`=1 and `Stb`=1, even byte pointers write the high byte of entry ptr/2, and odd pointers write its low byte. Then the pointer increments.
  - Bytes past 2·DEPTH are ignored; the pointer saturates.
  - `Stb` with `wr`=0 is ignored.
- **Length.** On the falling edge of `wr`, LEN := number of complete words written (pointer/2). A trailing odd byte lands in the table but is not counted.
  - A session with zero bytes sets LEN=0.
  - Table RAM is not reset; LEN resets to 0.
- **Write priority.** `wr`=1 forces state IDLE. `theBeanConfig` holds its current value and `seq_en` events are ignored.
- **State machine.** States are IDLE, RUN and STEP. Mode is latched as MODE_L on the start event.
  - **IDLE.**
    - A start event with LEN>0 and `mode`∈{01,10} goes to RUN: idx=0, output=mem[0], dwell counter=0.
    - A start event with `mode`=11 goes to STEP with output=mem[0] and idx=0.
    - An event with LEN=0 or `mode`=00 is ignored.
  - **RUN.**
    - The counter increments each cycle. At STEP_CYCLES−1 it clears and idx advances.
    - If idx was LEN−1: with MODE_L=01, go to IDLE holding mem[LEN−1]; with MODE_L=10, wrap to idx=0 and output mem[0].
    - Otherwise the output becomes mem[idx+1].
    - A start event in RUN restarts from entry 0 with the newly sampled mode.
  - **STEP.** Each start event advances idx, wrapping LEN−1→0, and outputs mem[idx]. `mode` leaving 11 returns to IDLE, holding the output.
- **Stop.** `mode`=00 in any state gives IDLE with `theBeanConfig`=0 at the next edge. Stop has priority over start events and lower priority than `wr` and `rst`.
- **Reset.** Reset gives IDLE, `theBeanConfig`=0, LEN=0, pointer=0 and counter=0. Reset mid-playback aborts immediately.

## Timing
- Reset values: `theBeanConfig`=16'h0000, IDLE.
- Start event sampled at edge N (seq_en=1 at N, 0 at N−1): `theBeanConfig`=mem[0] after edge N. The edge-detect register is combined with the current input, so latency is 1 edge.
- Automatic mode: entry k is visible for exactly STEP_CYCLES cycles. Entry k+1 appears STEP_CYCLES edges after entry k.
- A single pass lasts LEN·STEP_CYCLES cycles and then holds the last entry.
- A byte written at edge M is readable by playback starting at edge M+1 or later. Playback cannot overlap writes because `wr`=1 forces IDLE.
- LEN updates at the edge where `wr` is sampled 0 after being 1. A start event at that same edge sees the new LEN.
- Simultaneous cases:
  - `mode`=00 together with a start event: stop wins.
  - `wr`=1 together with a start event: the event is dropped.

## Test plan
- **Reset/no data:** rst 1 cycle; mode=01; seq_en pulse every 103 cycles; dato incrementing, wr=0 → `theBeanConfig` stays 16'h0000 indefinitely.
- **Load + single pass:** wr=1; strobe bytes 12,34,56,78,9A; wr=0 (LEN=2); mode=01; seq_en pulse → 1234 for 8 cycles, then 5678 held.
- **Loop:** same table, mode=10 → 1234, 5678 alternate every 8 cycles. Set mode=00 → 0000 on the next edge.
- **Manual step:** LEN=3 (1111, 2222, 3333); mode=11; 4 pulses → 1111, 2222, 3333, 1111. Holding seq_en high produces no further advance.
- **Retrigger/overflow:** restart mid-RUN → mem[0] on the next edge. Write 2·DEPTH+4 bytes → LEN=DEPTH, and the extra bytes leave mem[0] unchanged.
- **Write abort:** assert wr during RUN → output frozen and idle; a seq_en pulse with wr=1 has no effect.
